// File: rtl/bcd_counter_n_if.sv
// Bus bundle for the N-digit BCD counter: control/load inputs plus value, carry and sat outputs.
// The master modport is the controlling side; the slave modport is the counter itself.
interface bcd_counter_n_if #(
  parameter int DIGITS = 3
);
  logic                  count_en;
  logic                  up;
  logic                  load;
  logic [4*DIGITS-1:0]   load_val;
  logic [4*DIGITS-1:0]   data_out;
  logic                  carry;
  logic                  sat;

  modport master (
    output count_en, up, load, load_val,
    input  data_out, carry, sat
  );

  modport slave (
    input  count_en, up, load, load_val,
    output data_out, carry, sat
  );
endinterface

// File: rtl/bcd_counter_n.sv
// Parametrised N-digit up/down BCD counter with parallel load and terminal-count carry.
// Optional saturating mode is enabled by defining BCD_CNT_SAT_EN; otherwise the count wraps.
module bcd_counter_n #(
  parameter int DIGITS = 3
) (
  input  logic               clk,
  input  logic               reset,
  bcd_counter_n_if.slave     bus
);

  localparam int W = 4 * DIGITS;

  logic [W-1:0] value_q, value_d;
  logic [W-1:0] stepped;
  logic [W-1:0] clamped;
  logic         allNine;
  logic         allZero;
  logic         atLimit;
  logic         stepReq;

  // Limit detection across every digit, used for both carry and saturation.
  always_comb begin
    allNine = 1'b1;
    allZero = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (value_q[4*k +: 4] != 4'd9) allNine = 1'b0;
      if (value_q[4*k +: 4] != 4'd0) allZero = 1'b0;
    end
  end

  assign atLimit   = bus.up ? allNine : allZero;
  assign stepReq   = bus.count_en & ~bus.load;
  assign bus.carry = reset & stepReq & atLimit;

  // Single-cycle ripple: a digit steps only while every lower digit rolled over.
  always_comb begin
    logic       ripple;
    logic [3:0] nib;
    stepped = value_q;
    ripple  = 1'b1;
    nib     = 4'd0;
    for (int k = 0; k < DIGITS; k++) begin
      nib = value_q[4*k +: 4];
      if (ripple) begin
        if (bus.up) begin
          stepped[4*k +: 4] = (nib == 4'd9) ? 4'd0 : nib + 4'd1;
          ripple            = (nib == 4'd9);
        end else begin
          stepped[4*k +: 4] = (nib == 4'd0) ? 4'd9 : nib - 4'd1;
          ripple            = (nib == 4'd0);
        end
      end
    end
  end

  // Out-of-range load nibbles clamp to 9 so no non-BCD state is ever stored.
  always_comb begin
    logic [3:0] nib;
    clamped = '0;
    nib     = 4'd0;
    for (int k = 0; k < DIGITS; k++) begin
      nib               = bus.load_val[4*k +: 4];
      clamped[4*k +: 4] = (nib > 4'd9) ? 4'd9 : nib;
    end
  end

`ifdef BCD_CNT_SAT_EN
  logic sat_q, sat_d;

  always_comb begin
    value_d = value_q;
    sat_d   = sat_q;
    if (bus.load) begin
      value_d = clamped;
      sat_d   = 1'b0;
    end else if (bus.count_en) begin
      if (atLimit) begin
        sat_d = 1'b1;
      end else begin
        value_d = stepped;
        sat_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      value_q <= '0;
      sat_q   <= 1'b0;
    end else begin
      value_q <= value_d;
      sat_q   <= sat_d;
    end
  end

  assign bus.sat = sat_q;
`else
  always_comb begin
    value_d = value_q;
    if (bus.load) begin
      value_d = clamped;
    end else if (bus.count_en) begin
      value_d = stepped;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign bus.sat = 1'b0;
`endif

  assign bus.data_out = value_q;

endmodule

// File: tb/tb_bcd_counter_n.sv
// Self-checking bench for bcd_counter_n: directed scenarios plus randomized traffic
// compared against an integer-valued reference model; also checks a two-stage cascade.
module tb_bcd_counter_n;

  logic        clk = 1'b0;
  logic        rstN;
  logic        cntEn;
  logic        upDir;
  logic        ld;
  logic [11:0] ldVal;

  logic        chainRst;
  logic        chainEn;

  int checks = 0;
  int errors = 0;

  int mVal;
  bit mSat;

  always #5 clk = ~clk;

  // Main DUT, three digits.
  bcd_counter_n_if #(.DIGITS(3)) bus ();
  assign bus.count_en = cntEn;
  assign bus.up       = upDir;
  assign bus.load     = ld;
  assign bus.load_val = ldVal;

  bcd_counter_n #(.DIGITS(3)) dut (
    .clk   (clk),
    .reset (rstN),
    .bus   (bus)
  );

  // Cascade of two 2-digit counters alongside a 4-digit reference counter.
  bcd_counter_n_if #(.DIGITS(2)) lowIf ();
  bcd_counter_n_if #(.DIGITS(2)) highIf ();
  bcd_counter_n_if #(.DIGITS(4)) wideIf ();

  assign lowIf.count_en  = chainEn;
  assign lowIf.up        = 1'b1;
  assign lowIf.load      = 1'b0;
  assign lowIf.load_val  = 8'h00;
  assign highIf.count_en = lowIf.carry;
  assign highIf.up       = 1'b1;
  assign highIf.load     = 1'b0;
  assign highIf.load_val = 8'h00;
  assign wideIf.count_en = chainEn;
  assign wideIf.up       = 1'b1;
  assign wideIf.load     = 1'b0;
  assign wideIf.load_val = 16'h0000;

  bcd_counter_n #(.DIGITS(2)) lowCnt  (.clk(clk), .reset(chainRst), .bus(lowIf));
  bcd_counter_n #(.DIGITS(2)) highCnt (.clk(clk), .reset(chainRst), .bus(highIf));
  bcd_counter_n #(.DIGITS(4)) wideCnt (.clk(clk), .reset(chainRst), .bus(wideIf));

  // Reference model works on plain integers; BCD only appears at the comparison.
  function automatic logic [31:0] toBcd(input int v);
    logic [31:0] r;
    int t;
    r = '0;
    t = v;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic int loadToInt(input logic [11:0] lv);
    int sum;
    int mult;
    int d;
    sum  = 0;
    mult = 1;
    for (int i = 0; i < 3; i++) begin
      d = int'(lv[4*i +: 4]);
      if (d > 9) d = 9;
      sum  = sum + d * mult;
      mult = mult * 10;
    end
    return sum;
  endfunction

  function automatic logic expCarry();
    return rstN & cntEn & ~ld & (upDir ? (mVal == 999) : (mVal == 0));
  endfunction

  function automatic logic [11:0] expData();
    logic [31:0] b;
    b = toBcd(mVal);
    return b[11:0];
  endfunction

  task automatic modelStep();
    bit atLim;
    atLim = upDir ? (mVal == 999) : (mVal == 0);
    if (!rstN) begin
      mVal = 0;
      mSat = 1'b0;
    end else if (ld) begin
      mVal = loadToInt(ldVal);
      mSat = 1'b0;
    end else if (cntEn) begin
`ifdef BCD_CNT_SAT_EN
      if (atLim) begin
        mSat = 1'b1;
      end else begin
        mVal = upDir ? mVal + 1 : mVal - 1;
        mSat = 1'b0;
      end
`else
      mVal = upDir ? (mVal + 1) % 1000 : (mVal + 999) % 1000;
`endif
    end
  endtask

  task automatic applyStimulus(input logic r, input logic en, input logic u,
                               input logic l, input logic [11:0] lv);
    @(negedge clk);
    rstN  = r;
    cntEn = en;
    upDir = u;
    ld    = l;
    ldVal = lv;
    #1;
  endtask

  task automatic advanceClock();
    @(posedge clk);
    modelStep();
    #1;
  endtask

  task automatic test_reset();
    mVal = 0;
    mSat = 1'b0;
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 12'h555);
      checks++;
      if (bus.carry !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_carry: got %b expected 0", bus.carry);
      end
      advanceClock();
      checks++;
      if (bus.data_out !== 12'h000 || bus.sat !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_value: got %h sat %b expected 000 sat 0", bus.data_out, bus.sat);
      end
    end
  endtask

  task automatic test_load_increment();
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 12'h098);
    advanceClock();
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 12'h000);
      checks++;
      if (bus.carry !== 1'b0) begin
        errors++;
        $display("[TB] FAIL inc_carry: got %b expected 0", bus.carry);
      end
      advanceClock();
      checks++;
      if (bus.data_out !== expData()) begin
        errors++;
        $display("[TB] FAIL inc_value: got %h expected %h", bus.data_out, expData());
      end
    end
  endtask

  task automatic test_wrap_up();
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 12'h999);
    advanceClock();
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 12'h000);
    checks++;
    if (bus.carry !== 1'b1) begin
      errors++;
      $display("[TB] FAIL wrap_up_carry: got %b expected 1", bus.carry);
    end
    advanceClock();
    checks++;
    if (bus.data_out !== expData() || bus.sat !== mSat) begin
      errors++;
      $display("[TB] FAIL wrap_up_value: got %h sat %b expected %h sat %b",
               bus.data_out, bus.sat, expData(), mSat);
    end
  endtask

  task automatic test_wrap_down();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 12'h000);
    advanceClock();
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 12'h000);
      checks++;
      if (bus.carry !== expCarry()) begin
        errors++;
        $display("[TB] FAIL wrap_down_carry: step %0d got %b expected %b", i, bus.carry, expCarry());
      end
      advanceClock();
      checks++;
      if (bus.data_out !== expData() || bus.sat !== mSat) begin
        errors++;
        $display("[TB] FAIL wrap_down_value: step %0d got %h sat %b expected %h sat %b",
                 i, bus.data_out, bus.sat, expData(), mSat);
      end
    end
  endtask

  task automatic test_load_clamp();
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 12'hFA3);
    advanceClock();
    checks++;
    if (bus.data_out !== 12'h993) begin
      errors++;
      $display("[TB] FAIL load_clamp: got %h expected 993", bus.data_out);
    end
    // Loading the terminal value while counting must not wrap or pulse carry.
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 12'h999);
    checks++;
    if (bus.carry !== 1'b0) begin
      errors++;
      $display("[TB] FAIL load_priority_carry: got %b expected 0", bus.carry);
    end
    advanceClock();
    checks++;
    if (bus.data_out !== 12'h999) begin
      errors++;
      $display("[TB] FAIL load_priority_value: got %h expected 999", bus.data_out);
    end
  endtask

  task automatic test_reset_midcount();
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 12'h457);
    advanceClock();
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 12'h000);
    advanceClock();
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 12'h999);
    checks++;
    if (bus.carry !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midreset_carry: got %b expected 0", bus.carry);
    end
    advanceClock();
    checks++;
    if (bus.data_out !== 12'h000) begin
      errors++;
      $display("[TB] FAIL midreset_value: got %h expected 000", bus.data_out);
    end
  endtask

  task automatic test_hold();
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 12'h999);
    advanceClock();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b0, 1'($urandom_range(1)), 1'b0, 12'($urandom));
      checks++;
      if (bus.carry !== 1'b0) begin
        errors++;
        $display("[TB] FAIL hold_carry: got %b expected 0", bus.carry);
      end
      advanceClock();
      checks++;
      if (bus.data_out !== 12'h999) begin
        errors++;
        $display("[TB] FAIL hold_value: got %h expected 999", bus.data_out);
      end
    end
  endtask

  task automatic test_random();
    logic [11:0] lv;
    for (int i = 0; i < 400; i++) begin
      lv = 12'($urandom);
      if ($urandom_range(3) == 0) lv = ($urandom_range(1) == 1) ? 12'h998 : 12'h001;
      applyStimulus(($urandom_range(40) != 0), ($urandom_range(3) != 0),
                    ($urandom_range(7) < 5), ($urandom_range(15) == 0), lv);
      checks++;
      if (bus.carry !== expCarry()) begin
        errors++;
        $display("[TB] FAIL rand_carry: cycle %0d got %b expected %b", i, bus.carry, expCarry());
      end
      advanceClock();
      checks++;
      if (bus.data_out !== expData()) begin
        errors++;
        $display("[TB] FAIL rand_value: cycle %0d got %h expected %h", i, bus.data_out, expData());
      end
      checks++;
      if (bus.sat !== mSat) begin
        errors++;
        $display("[TB] FAIL rand_sat: cycle %0d got %b expected %b", i, bus.sat, mSat);
      end
    end
  endtask

  task automatic test_chain();
    logic [31:0] b;
    @(negedge clk);
    chainRst = 1'b0;
    chainEn  = 1'b0;
    @(negedge clk);
    chainRst = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      chainEn = 1'b1;
      @(posedge clk);
      #1;
      b = toBcd(i % 10000);
      checks++;
      if ({highIf.data_out, lowIf.data_out} !== b[15:0] || wideIf.data_out !== b[15:0]) begin
        errors++;
        $display("[TB] FAIL chain_step: step %0d got high %h low %h wide %h expected %h",
                 i, highIf.data_out, lowIf.data_out, wideIf.data_out, b[15:0]);
      end
    end
    @(negedge clk);
    chainEn = 1'b0;
    checks++;
    if (lowIf.data_out !== 8'h00 || highIf.data_out !== 8'h01 || wideIf.data_out !== 16'h0100) begin
      errors++;
      $display("[TB] FAIL chain_final: got high %h low %h wide %h expected 01 00 0100",
               highIf.data_out, lowIf.data_out, wideIf.data_out);
    end
  endtask

  initial begin
    chainRst = 1'b0;
    chainEn  = 1'b0;
    test_reset();
    test_load_increment();
    test_wrap_up();
    test_wrap_down();
    test_load_clamp();
    test_reset_midcount();
    test_hold();
    test_random();
`ifndef BCD_CNT_SAT_EN
    test_chain();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
